// File: rtl/dds_parallel_pkg.sv
// Shared constants and the elaboration-time quarter-wave sine helper.
package dds_parallel_pkg;

  localparam int LUT_AW_DEF     = 10;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int Q              = 2 ** LUT_AW_DEF;
  localparam int AMP            = 2 ** (DATA_WIDTH_DEF - 1) - 1;
  localparam real PI_HALF       = 1.5707963267948966;

  // Quarter-wave entry i of a table with 2^aw steps and dw-bit signed amplitude.
  // The argument lies in [0, pi/2], so the result is never negative and rounding
  // is simply +0.5 followed by truncation.
  function automatic int sin_q(input int i, input int aw, input int dw);
    real amp;
    real x;
    amp = real'((2 ** (dw - 1)) - 1);
    x   = amp * $sin(PI_HALF * real'(i) / real'(2 ** aw));
    return $rtoi(x + 0.5);
  endfunction

endpackage

// File: rtl/dds_sin_lut.sv
// One sine channel: quadrant fold plus table read, then sign restore.
module dds_sin_lut #(
  parameter int PINC_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LUT_AW     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PINC_WIDTH-1:0] phase,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] sample
);
  import dds_parallel_pkg::*;

  localparam int QN = 2 ** LUT_AW;
  localparam logic [LUT_AW:0] Q_IDX = (LUT_AW + 1)'(QN);

  logic [DATA_WIDTH-1:0] tab [0:QN];
  logic [1:0]            quad;
  logic [LUT_AW-1:0]     addr;
  logic [LUT_AW:0]       idx;
  logic [DATA_WIDTH-1:0] mag;
  logic                  neg;

  for (genvar i = 0; i <= QN; i++) begin : g_tab
    assign tab[i] = DATA_WIDTH'(sin_q(i, LUT_AW, DATA_WIDTH));
  end

  // Phase bits below the table address are truncated on purpose.
  if (PINC_WIDTH > LUT_AW + 2) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^phase[PINC_WIDTH-LUT_AW-3:0];
  end

  assign quad = phase[PINC_WIDTH-1 -: 2];
  assign addr = phase[PINC_WIDTH-3 -: LUT_AW];
  // Odd quadrants walk the table backwards; entry Q exists so a=0 maps to full scale.
  assign idx  = quad[0] ? (Q_IDX - {1'b0, addr}) : {1'b0, addr};

  // Two-stage pipeline: magnitude/sign, then signed output sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag    <= '0;
      neg    <= 1'b0;
      sample <= '0;
    end else if (enable) begin
      mag    <= tab[idx];
      neg    <= quad[1];
      sample <= neg ? -mag : mag;
    end
  end

endmodule

// File: rtl/dds_parallel.sv
// Polyphase DDS: one phase increment in, DDS_CHANNEL consecutive samples out per clock.
module dds_parallel #(
  parameter int DDS_CHANNEL = 8,
  parameter int PINC_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int LUT_AW      = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PINC_WIDTH-1:0]             pinc_axis_tdata,
  output logic                              pinc_axis_tready,
  output logic [DATA_WIDTH*DDS_CHANNEL-1:0] m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready
);
  import dds_parallel_pkg::*;

  logic                  run;
  logic                  adv;
  logic [PINC_WIDTH-1:0] pinc_r;
  logic [PINC_WIDTH-1:0] acc;
  logic [PINC_WIDTH-1:0] ph [DDS_CHANNEL];
  // vld_sr[0]: pinc_r holds a sampled increment, [1]: phases valid, [2]: magnitudes valid.
  logic [2:0]            vld_sr;

  assign adv              = ~m_axis_tvalid | m_axis_tready;
  assign pinc_axis_tready = run & adv;

  // Run flag, increment capture, accumulator, per-channel phases and valid tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run           <= 1'b0;
      pinc_r        <= '0;
      acc           <= '0;
      vld_sr        <= '0;
      m_axis_tvalid <= 1'b0;
      for (int k = 0; k < DDS_CHANNEL; k++) begin
        ph[k] <= '0;
      end
    end else begin
      run <= 1'b1;
      if (adv) begin
        if (run) begin
          pinc_r <= pinc_axis_tdata;
        end
        acc           <= acc + PINC_WIDTH'(DDS_CHANNEL) * pinc_r;
        vld_sr        <= {vld_sr[1:0], run};
        m_axis_tvalid <= vld_sr[2];
        for (int k = 0; k < DDS_CHANNEL; k++) begin
          ph[k] <= acc + PINC_WIDTH'(k) * pinc_r;
        end
      end
    end
  end

  for (genvar k = 0; k < DDS_CHANNEL; k++) begin : g_ch
    dds_sin_lut #(
      .PINC_WIDTH(PINC_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .LUT_AW    (LUT_AW)
    ) u_lut (
      .clk   (clk),
      .rst_n (rst_n),
      .phase (ph[k]),
      .enable(adv),
      .sample(m_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_dds_parallel.sv
// Directed bench for dds_parallel with N=8, P=16, D=16, LUT_AW=10.
module tb_dds_parallel;

  logic         clk;
  logic         rst_n;
  logic [15:0]  pinc;
  logic         pinc_rdy;
  logic [127:0] tdata;
  logic         tvalid;
  logic         mtr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0]  pinc;
    logic [127:0] word;
  } vec_t;

  vec_t vecs [4];

  dds_parallel #(
    .DDS_CHANNEL(8),
    .PINC_WIDTH (16),
    .DATA_WIDTH (16),
    .LUT_AW     (10)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pinc_axis_tdata (pinc),
    .pinc_axis_tready(pinc_rdy),
    .m_axis_tdata    (tdata),
    .m_axis_tvalid   (tvalid),
    .m_axis_tready   (mtr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Sample value at a 16-bit phase, straight from the quadrant/table definition.
  function automatic logic [15:0] s_of(input logic [15:0] ph);
    logic [1:0] q;
    int a;
    int idx;
    int mag;
    q   = ph[15:14];
    a   = int'(ph[13:4]);
    idx = q[0] ? 1024 - a : a;
    mag = $rtoi(32767.0 * $sin(1.5707963267948966 * real'(idx) / 1024.0) + 0.5);
    if (q[1]) mag = -mag;
    return 16'(mag);
  endfunction

  // Output word n for an increment held constant since reset.
  function automatic logic [127:0] word_of(input int n, input int p);
    logic [127:0] w;
    longint ph;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      ph = ((longint'(n) * 8 + k) * p) % 65536;
      w[16*k +: 16] = s_of(16'(ph));
    end
    return w;
  endfunction

  task automatic do_reset(input logic [15:0] p);
    rst_n = 1'b0;
    pinc  = p;
    mtr   = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string nm);
    int c;
    c = 0;
    @(negedge clk);
    while (!tvalid && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_valid_seen"}, 128'(tvalid), 128'd1);
  endtask

  task automatic run_const(input logic [15:0] p, input int nw, input string nm);
    do_reset(p);
    wait_valid(nm);
    for (int n = 0; n < nw; n++) begin
      chk($sformatf("%s_w%0d", nm, n), tdata, word_of(n, int'(p)));
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pinc  = 16'd16384;
    mtr   = 1'b1;

    vecs[0] = '{16'd16384, 128'h8001_0000_7FFF_0000_8001_0000_7FFF_0000};
    vecs[1] = '{16'd8192,  128'hA57E_8001_A57E_0000_5A82_7FFF_5A82_0000};
    vecs[2] = '{16'd32768, 128'h0};
    vecs[3] = '{16'd0,     128'h0};

    // reset and start-up timing
    repeat (10) @(negedge clk);
    chk("rst_tvalid", 128'(tvalid), 128'd0);
    chk("rst_tdata", tdata, 128'd0);
    chk("rst_tready", 128'(pinc_rdy), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("start_tready", 128'(pinc_rdy), 128'd1);
    chk("start_tvalid", 128'(tvalid), 128'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("start_tvalid_e%0d", i + 1), 128'(tvalid), 128'(i == 3));
    end
    chk("start_first_word", tdata, vecs[0].word);

    // constant-increment patterns with hand-computed words
    for (int v = 0; v < 4; v++) begin
      do_reset(vecs[v].pinc);
      wait_valid($sformatf("vec%0d", v));
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("vec%0d_w%0d", v, n), tdata, vecs[v].word);
        @(negedge clk);
      end
    end

    // irregular increment against the golden phase model
    run_const(16'd11796, 12, "p11796");

    // pinc 0 then switch to 16384: three more zero words, then the pattern
    do_reset(16'd0);
    wait_valid("switch");
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("switch_zero_w%0d", n), tdata, 128'd0);
      @(negedge clk);
    end
    pinc = 16'd16384;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk($sformatf("switch_c%0d", n + 1), tdata, (n < 3) ? 128'd0 : vecs[0].word);
    end

    // backpressure: five stalled cycles mid-stream
    begin
      int n;
      n = 0;
      do_reset(16'd11796);
      wait_valid("bp");
      for (int i = 0; i < 30; i++) begin
        mtr = !(i >= 8 && i <= 12);
        #1;
        if (tvalid) begin
          chk($sformatf("bp_c%0d_word%0d", i, n), tdata, word_of(n, 11796));
          if (mtr) n++;
          else chk($sformatf("bp_c%0d_tready", i), 128'(pinc_rdy), 128'd0);
        end
        @(negedge clk);
      end
      mtr = 1'b1;
      chk("bp_words_accepted", 128'(n), 128'd25);
    end

    // asynchronous reset between edges, then restart from acc=0
    run_const(16'd11796, 5, "pre_mid");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 128'(tvalid), 128'd0);
    chk("mid_rst_tdata", tdata, 128'd0);
    chk("mid_rst_tready", 128'(pinc_rdy), 128'd0);
    run_const(16'd11796, 6, "post_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
